// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one read per fetch request on a
// valid/ready address channel, captures the word on a valid/ready data channel
// and presents it with its PC as a one-cycle inst_valid pulse.
module fetch_unit #(
   parameter int unsigned           pc_width   = 32,
   parameter int unsigned           inst_width = 32,
   parameter logic [pc_width-1:0]   pc_init    = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  inst_fetch,
   input  logic                  pc_load,
   input  logic [pc_width-1:0]   pc_next,
   output logic [pc_width-1:0]   ir_addr,
   output logic                  ir_addr_valid,
   input  logic                  ir_addr_ready,
   input  logic [inst_width-1:0] ir_data,
   input  logic                  ir_data_valid,
   output logic                  ir_data_ready,
   output logic [inst_width-1:0] inst,
   output logic [pc_width-1:0]   inst_pc,
   output logic                  inst_valid,
   output logic                  busy
);

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StAddr = 2'b01,
      StData = 2'b10
   } state_e;

   state_e state_q;

   // Only the word index is stored, so the PC is word aligned by construction.
   logic [pc_width-3:0] pc_word_q;
   logic [pc_width-1:0] addr_q;
   logic [pc_width-1:0] pc;

   // Byte-offset bits of the branch target are deliberately dropped.
   logic unused_pc_next_bits;
   assign unused_pc_next_bits = ^pc_next[1:0];

   assign pc = {pc_word_q, 2'b00};

   // Bus handshake outputs depend on state only, never on same-cycle inputs.
   always_comb begin
      ir_addr       = addr_q;
      ir_addr_valid = (state_q == StAddr);
      ir_data_ready = (state_q == StData);
      busy          = (state_q == StAddr) || (state_q == StData);
   end

   // Fetch FSM with registered instruction outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         inst       <= '0;
         inst_pc    <= '0;
         inst_valid <= 1'b0;
      end else begin
         inst_valid <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (inst_fetch) begin
                  addr_q  <= pc;
                  state_q <= StAddr;
               end
            end
            StAddr: begin
               if (ir_addr_ready) begin
                  state_q <= StData;
               end
            end
            StData: begin
               if (ir_data_valid) begin
                  inst       <= ir_data;
                  inst_pc    <= addr_q;
                  inst_valid <= 1'b1;
                  state_q    <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Program counter: a branch/jump load takes priority over the post-capture increment.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_word_q <= pc_init[pc_width-1:2];
      end else if (pc_load) begin
         pc_word_q <= pc_next[pc_width-1:2];
      end else if ((state_q == StData) && ir_data_valid) begin
         pc_word_q <= pc_word_q + (pc_width-2)'(1);
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a bench-side slave model answers bus
// reads, expected (pc, inst) pairs are queued when a fetch is issued and
// compared when inst_valid is seen.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_fetch, pc_load;
   logic [31:0] pc_next;
   logic [31:0] ir_addr;
   logic        ir_addr_valid, ir_addr_ready;
   logic [31:0] ir_data;
   logic        ir_data_valid, ir_data_ready;
   logic [31:0] inst, inst_pc;
   logic        inst_valid, busy;

   // Second instance with a PC reset value near the top of the address space.
   logic        inst_fetch_w, pc_load_w;
   logic [31:0] pc_next_w;
   logic [31:0] ir_addr_w;
   logic        ir_addr_valid_w, ir_addr_ready_w;
   logic [31:0] ir_data_w;
   logic        ir_data_valid_w, ir_data_ready_w;
   logic [31:0] inst_w, inst_pc_w;
   logic        inst_valid_w, busy_w;

   always #5 clk = ~clk;

   fetch_unit #(.pc_width(32), .inst_width(32), .pc_init(32'h0)) dut (
      .clk(clk), .rst(rst), .inst_fetch(inst_fetch), .pc_load(pc_load), .pc_next(pc_next),
      .ir_addr(ir_addr), .ir_addr_valid(ir_addr_valid), .ir_addr_ready(ir_addr_ready),
      .ir_data(ir_data), .ir_data_valid(ir_data_valid), .ir_data_ready(ir_data_ready),
      .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .busy(busy)
   );

   fetch_unit #(.pc_width(32), .inst_width(32), .pc_init(32'hFFFF_FFFC)) dut_w (
      .clk(clk), .rst(rst), .inst_fetch(inst_fetch_w), .pc_load(pc_load_w),
      .pc_next(pc_next_w), .ir_addr(ir_addr_w), .ir_addr_valid(ir_addr_valid_w),
      .ir_addr_ready(ir_addr_ready_w), .ir_data(ir_data_w), .ir_data_valid(ir_data_valid_w),
      .ir_data_ready(ir_data_ready_w), .inst(inst_w), .inst_pc(inst_pc_w),
      .inst_valid(inst_valid_w), .busy(busy_w)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
   } exp_t;

   exp_t        exp_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          ncyc = 0;
   int          n_iv = 0;
   int          iv_cyc = 0;
   logic        prev_iv = 1'b0;
   int          a_cnt = 0;
   int          d_cnt = 0;
   logic        ld_cap = 1'b0;
   logic [31:0] ld_cap_tgt = '0;
   logic        ld_now = 1'b0;
   logic [31:0] ld_now_tgt = '0;
   logic        force_dv = 1'b0;
   logic [31:0] slave_addr = '0;
   logic [31:0] m_pc = '0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Instruction memory contents seen by the slave model.
   function automatic logic [31:0] mem(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
   endfunction

   // Drive one cycle of slave/control inputs, clock, then monitor outputs.
   task automatic tick();
      pc_load       = ld_now;
      pc_next       = ld_now_tgt;
      ld_now        = 1'b0;
      ir_addr_ready = 1'b0;
      ir_data_valid = force_dv;
      if (ir_addr_valid) begin
         if (exp_q.size() > 0) check_val("addr_value", ir_addr, exp_q[0].pc);
         if (a_cnt > 0) a_cnt--;
         else begin
            ir_addr_ready = 1'b1;
            slave_addr    = ir_addr;
         end
      end
      ir_data = mem(slave_addr);
      if (ir_data_ready) begin
         if (d_cnt > 0) d_cnt--;
         else begin
            ir_data_valid = 1'b1;
            if (ld_cap) begin
               pc_load = 1'b1;
               pc_next = ld_cap_tgt;
               ld_cap  = 1'b0;
            end
         end
      end
      @(posedge clk);
      #1;
      ncyc++;
      if (inst_valid) begin
         check_val("iv_single_cycle", {31'b0, prev_iv}, 32'h0);
         if (exp_q.size() == 0) begin
            check_val("spurious_inst_valid", 32'h1, 32'h0);
         end else begin
            exp_t e = exp_q.pop_front();
            check_val("inst", inst, e.word);
            check_val("inst_pc", inst_pc, e.pc);
         end
         n_iv++;
         iv_cyc = ncyc;
      end
      prev_iv = inst_valid;
   endtask

   // One fetch with given stall counts; optional load in the request cycle
   // and/or in the data capture cycle.
   task automatic do_fetch(input int as, input int ds, input logic idle_ld,
                           input logic [31:0] idle_tgt, input logic cap_ld,
                           input logic [31:0] cap_tgt, input int exp_lat);
      int   start;
      int   n0;
      exp_t e;
      e.pc   = m_pc;
      e.word = mem(m_pc);
      exp_q.push_back(e);
      if (idle_ld) m_pc = {idle_tgt[31:2], 2'b00};
      a_cnt      = as;
      d_cnt      = ds;
      ld_now     = idle_ld;
      ld_now_tgt = idle_tgt;
      ld_cap     = cap_ld;
      ld_cap_tgt = cap_tgt;
      start      = ncyc;
      n0         = n_iv;
      inst_fetch = 1'b1;
      tick();
      inst_fetch = 1'b0;
      while (n_iv == n0 && ncyc - start < 40) tick();
      if (n_iv == n0) begin
         check_val("fetch_timeout", 32'h1, 32'h0);
         exp_q.delete();
      end else begin
         check_val("latency", iv_cyc - start, exp_lat);
      end
      m_pc = cap_ld ? {cap_tgt[31:2], 2'b00} : m_pc + 32'd4;
      tick();
      tick();
      check_val("one_pulse", n_iv - n0, 32'd1);
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      m_pc = 32'h0;
      exp_q.delete();
   endtask

   initial begin
      logic [31:0] wa[4];
      int          nw;
      int          st;
      int          n0;
      int          last_iv;
      inst_fetch = 1'b0; pc_load = 1'b0; pc_next = '0;
      ir_addr_ready = 1'b0; ir_data = '0; ir_data_valid = 1'b0;
      inst_fetch_w = 1'b0; pc_load_w = 1'b0; pc_next_w = '0;
      ir_addr_ready_w = 1'b0; ir_data_w = 32'h0000_0013; ir_data_valid_w = 1'b0;
      apply_reset();

      check_val("rst_inst", inst, 32'h0);
      check_val("rst_inst_pc", inst_pc, 32'h0);
      check_val("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
      check_val("rst_busy", {31'b0, busy}, 32'h0);
      check_val("rst_addr_valid", {31'b0, ir_addr_valid}, 32'h0);
      check_val("rst_data_ready", {31'b0, ir_data_ready}, 32'h0);

      // Single zero-wait fetch from address 0.
      do_fetch(0, 0, 1'b0, '0, 1'b0, '0, 3);
      // Address and data stalls: 2 + 3 extra cycles.
      a_cnt = 0;
      do_fetch(2, 3, 1'b0, '0, 1'b0, '0, 8);

      // Point PC at 0x10, then branch to 0x203 in the capture cycle.
      ld_now = 1'b1; ld_now_tgt = 32'h0000_0013;
      tick();
      m_pc = 32'h10;
      do_fetch(0, 1, 1'b0, '0, 1'b1, 32'h0000_0203, 4);
      do_fetch(0, 0, 1'b0, '0, 1'b0, '0, 3);
      // Fetch and load in the same idle cycle: fetch uses old PC, then PC = 0x40 + 4.
      do_fetch(0, 0, 1'b1, 32'h0000_0040, 1'b0, '0, 3);
      do_fetch(0, 0, 1'b0, '0, 1'b0, '0, 3);

      // Reset while stalled in DATA; a late response must be ignored.
      m_pc = 32'h0;
      a_cnt = 0; d_cnt = 100;
      inst_fetch = 1'b1;
      tick();
      inst_fetch = 1'b0;
      tick();
      tick();
      check_val("mid_busy", {31'b0, busy}, 32'h1);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check_val("mid_rst_busy", {31'b0, busy}, 32'h0);
      force_dv = 1'b1;
      n0 = n_iv;
      tick(); tick(); tick();
      force_dv = 1'b0;
      check_val("mid_rst_no_iv", n_iv - n0, 32'd0);
      check_val("mid_rst_inst", inst, 32'h0);
      check_val("mid_rst_inst_pc", inst_pc, 32'h0);
      do_fetch(0, 0, 1'b0, '0, 1'b0, '0, 3);

      // Continuous request: one transaction every 3 cycles, addresses 0, 4, 8, 12.
      apply_reset();
      inst_fetch = 1'b1;
      last_iv = 0;
      for (int k = 0; k < 4; k++) begin
         exp_t e;
         e.pc   = m_pc;
         e.word = mem(m_pc);
         exp_q.push_back(e);
         n0 = n_iv;
         st = ncyc;
         while (n_iv == n0 && ncyc - st < 20) tick();
         if (k == 3) inst_fetch = 1'b0;
         if (n_iv == n0) begin
            check_val("stream_timeout", 32'h1, 32'h0);
            exp_q.delete();
         end else if (k > 0) begin
            check_val("stream_gap", iv_cyc - last_iv, 32'd3);
         end
         last_iv = iv_cyc;
         m_pc = m_pc + 32'd4;
      end
      tick(); tick(); tick();
      check_val("stream_idle", {31'b0, busy}, 32'h0);
      check_val("stream_queue_empty", exp_q.size(), 32'd0);

      // Wrap from 0xFFFFFFFC to 0 on the second instance.
      nw = 0;
      ir_addr_ready_w = 1'b1;
      ir_data_valid_w = 1'b1;
      inst_fetch_w    = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk);
         #1;
         if (ir_addr_valid_w && nw < 4) begin
            wa[nw] = ir_addr_w;
            nw++;
         end
      end
      inst_fetch_w = 1'b0;
      check_val("wrap_count", nw, 32'd3);
      if (nw >= 2) begin
         check_val("wrap_addr0", wa[0], 32'hFFFF_FFFC);
         check_val("wrap_addr1", wa[1], 32'h0000_0000);
      end
      check_val("wrap_inst_pc", inst_pc_w, 32'h0000_0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the copperv core, directly upstream of `control_unit`. On each `inst_fetch` request, it issues one read on the instruction bus using a valid/ready address channel and a valid/ready data channel. It captures the returned word and presents it, with its PC, to the decode/control logic as a one-cycle `inst_valid` pulse. It owns the program counter: sequential increment by 4, or a load from the execute stage for branches and jumps.

## Interface
Parameters:
- `pc_width`, 32, width of PC and bus address
- `inst_width`, 32, width of instruction word
- `pc_init`, 0, PC value after reset (multiple of 4)

Ports:
- `clk`  in  1  core clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-low reset
- `inst_fetch`  in  1  fetch request from control_unit; sampled only in IDLE
- `pc_load`  in  1  load `pc_next` into PC (branch/jump)
- `pc_next`  in  pc_width  target address; bits [1:0] ignored (treated as 0)
- `ir_addr`  out  pc_width  instruction bus read address
- `ir_addr_valid`  out  1  address channel valid
- `ir_addr_ready`  in  1  address channel ready
- `ir_data`  in  inst_width  instruction bus read data
- `ir_data_valid`  in  1  data channel valid
- `ir_data_ready`  out  1  data channel ready
- `inst`  out  inst_width  last fetched instruction; held until next capture
- `inst_pc`  out  pc_width  address `inst` was fetched from
- `inst_valid`  out  1  one-cycle pulse: new `inst`/`inst_pc` available
- `busy`  out  1  high in ADDR or DATA

## Operation
- Registers:
  - `pc`: next fetch address
  - `addr_q`: in-flight address
  - `inst`, `inst_pc`, `inst_valid`
  - state
- FSM states are IDLE, ADDR, DATA.
- **IDLE**: if `inst_fetch`=1, then `addr_q` <= `pc` and go to ADDR. Otherwise stay.
- **ADDR**: `ir_addr_valid`=1 and `ir_addr`=`addr_q`.
  - If `ir_addr_ready`=1, the handshake completes this cycle; go to DATA.
  - `ir_addr` and `ir_addr_valid` are stable until the handshake.
- **DATA**: `ir_data_ready`=1.
  - If `ir_data_valid`=1, then `inst` <= `ir_data`, `inst_pc` <= `addr_q`, `inst_valid` <= 1 for exactly one cycle, `pc` <= `pc`+4, and go to IDLE.
- `ir_addr_valid` and `ir_data_ready` are combinational from state only. They never depend on same-cycle inputs.
- PC arithmetic:
  - `pc`+4 is modulo 2^pc_width; 0xFFFFFFFC wraps to 0x00000000.
  - `pc[1:0]` is always 0.
- `pc_load` is accepted in any state and writes {`pc_next`[pc_width-1:2],2'b00} into `pc`.
  - An in-flight transaction is not aborted. `addr_q` is unaffected, and the captured instruction still reports the old `addr_q`.
  - If `pc_load` and data capture occur in the same cycle, `pc_load` wins over +4.
- `inst_fetch` in ADDR or DATA is ignored; it is neither queued nor counted.
- `inst_fetch` and `pc_load` in the same IDLE cycle: the fetch uses the old `pc`, and `pc` takes `pc_next`.
- Reset (`rst`=0 at a clock edge), in any state including mid-transaction:
  - state=IDLE, `pc`=`pc_init`, `addr_q`=0
  - `inst`=0, `inst_pc`=0, `inst_valid`=0
  - hence `ir_addr_valid`=0, `ir_data_ready`=0, `busy`=0 from the next cycle
  - An outstanding bus response arriving after reset is ignored, because `ir_data_ready` is 0.

## Timing
- Request in cycle N (IDLE): `ir_addr_valid`=1 from cycle N+1.
- Zero-wait slave (`ir_addr_ready`=1 in N+1, `ir_data_valid`=1 in N+2): `inst_valid`=1 in N+3. This is the minimum latency, 3 cycles.
- Each address-ready stall and each data-valid stall adds one cycle.
- Back-to-back: `inst_fetch` may be asserted in the cycle `inst_valid` is high (state is IDLE). The next `ir_addr_valid` then appears one cycle later. Maximum throughput is one instruction per 3 cycles.
- `inst_valid` is never high for two consecutive cycles.

## Test plan
- **Reset + single fetch**: `pc_init`=0, zero-wait slave returning 0x00500093 for addr 0, `inst_fetch` pulse at cycle 0 → `ir_addr`=0 valid at cycle 1; `inst`=0x00500093, `inst_pc`=0, `inst_valid` at cycle 3; next fetch address is 4.
- **Stalls**: `ir_addr_ready` low 2 cycles, then `ir_data_valid` low 3 cycles → `ir_addr` held constant throughout; `inst_valid` at cycle 8; exactly one pulse.
- **Branch during DATA**: fetch at 0x10, `pc_load`=1 with `pc_next`=0x203 in the capture cycle → `inst_pc`=0x10; next fetch address is 0x200, not 0x14.
- **Wrap**: `pc_init`=0xFFFFFFFC, two fetches → `ir_addr` 0xFFFFFFFC, then 0x00000000.
- **Reset mid-transaction**: `rst`=0 while in DATA, slave asserts `ir_data_valid` after reset release → no `inst_valid`, `inst`=0, `pc`=`pc_init`; next fetch is from `pc_init`.
- **Ignored request**: `inst_fetch` held high continuously with a zero-wait slave → one bus transaction every 3 cycles, addresses 0, 4, 8, …; no overlapping `ir_addr_valid`.
